// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file with a fixed-priority interrupt controller.
// Sequences interrupt entry through a flush window and returns on mret.
module csr_irq_ctrl #(
    parameter int unsigned NUM_IRQ      = 4,
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [31:0] HARTID       = 32'd0,
    parameter bit          VECTORED     = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               csr_wr_i,
    input  logic [11:0]        addr_i,
    input  logic [1:0]         mode_sel_i,
    input  logic [4:0]         immed_i,
    input  logic               immed_sel_i,
    input  logic [31:0]        rs1_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               timer_intr_i,
    input  logic               stall_i,
    input  logic               hold_i,
    input  logic               mret_i,
    input  logic               ctrl_change_i,
    input  logic [31:0]        next_pc_i,
    output logic [31:0]        csr_data_o,
    output logic               flush_o,
    output logic               pc_intr_sel_o,
    output logic [31:0]        pc_intr_addr_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic               busy_o
);

    localparam logic [31:0] MIE_MASK = 32'(((64'd1 << NUM_IRQ) - 64'd1) << 16) | 32'h80;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {IDLE, ENTRY, ACTIVE} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q;
    logic                mstatus_mie_q, mstatus_mpie_q;
    logic [31:0]         mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [NUM_IRQ-1:0]  irq_ack_q;

    logic [31:0]         mip, pending, wdata, mstatus_rd, mstatus_new;
    logic [31:0]         win_cause, target;
    logic [NUM_IRQ-1:0]  win_ack;
    logic                wr_en, accept, mret_take, cause_lock;

    function automatic logic [31:0] csr_op(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [1:0] mode);
        case (mode)
            2'b01:   return wd;
            2'b10:   return old | wd;
            2'b11:   return old & ~wd;
            default: return old;
        endcase
    endfunction

    always_comb begin
        mip              = '0;
        mip[7]           = timer_intr_i;
        mip[16 +: NUM_IRQ] = irq_i;
    end

    assign pending     = mip & mie_q;
    assign wdata       = immed_sel_i ? {27'b0, immed_i} : rs1_i;
    assign wr_en       = csr_wr_i && (mode_sel_i != 2'b00);
    assign mstatus_rd  = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign mstatus_new = csr_op(mstatus_rd, wdata, mode_sel_i);
    assign accept      = (state_q == IDLE) && mstatus_mie_q && (pending != '0);
    assign mret_take   = (state_q == ACTIVE) && mret_i;
    assign cause_lock  = accept || (state_q == ENTRY) || mret_take;

    // Walk from lowest priority up so the lowest-numbered line wins.
    always_comb begin
        win_cause = {1'b1, 31'd7};
        win_ack   = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (pending[16 + k]) begin
                win_cause  = {1'b1, 31'(16 + k)};
                win_ack    = '0;
                win_ack[k] = 1'b1;
            end
        end
    end

    always_comb begin
        target = {mtvec_q[31:2], 2'b00};
        if (VECTORED && mtvec_q[0])
            target = {mtvec_q[31:2], 2'b00} + {25'b0, mcause_q[4:0], 2'b00};
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ENTRY;
            ENTRY:   if ((cnt_q == 3'd1) && !stall_i && !hold_i) state_d = ACTIVE;
            ACTIVE:  if (mret_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        flush_o        = 1'b0;
        pc_intr_sel_o  = 1'b0;
        pc_intr_addr_o = '0;
        if (state_q == ENTRY) begin
            flush_o = (cnt_q > 3'd1);
            if (cnt_q == 3'd1) begin
                pc_intr_sel_o  = 1'b1;
                pc_intr_addr_o = target;
            end
        end else if (mret_take) begin
            pc_intr_sel_o  = 1'b1;
            pc_intr_addr_o = mepc_q;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign irq_ack_o = irq_ack_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q          <= '0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            irq_ack_q      <= '0;
        end else begin
            irq_ack_q <= accept ? win_ack : '0;

            if (accept)
                cnt_q <= 3'(FLUSH_CYCLES);
            else if ((state_q == ENTRY) && !stall_i) begin
                // Park at 1 while hold_i keeps the redirect asserted.
                if (cnt_q > 3'd1)  cnt_q <= cnt_q - 3'd1;
                else if (!hold_i)  cnt_q <= '0;
            end

            if (accept) begin
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (mret_take) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (wr_en && (addr_i == A_MSTATUS)) begin
                mstatus_mie_q  <= mstatus_new[3];
                mstatus_mpie_q <= mstatus_new[7];
            end

            if (wr_en && (addr_i == A_MIE))
                mie_q <= csr_op(mie_q, wdata, mode_sel_i) & MIE_MASK;
            if (wr_en && (addr_i == A_MTVEC))
                mtvec_q <= csr_op(mtvec_q, wdata, mode_sel_i) & 32'hFFFF_FFFD;
            if (wr_en && (addr_i == A_MSCRATCH))
                mscratch_q <= csr_op(mscratch_q, wdata, mode_sel_i);

            if (accept || ((state_q == ENTRY) && ctrl_change_i))
                mepc_q <= next_pc_i & 32'hFFFF_FFFC;
            else if (wr_en && !cause_lock && (addr_i == A_MEPC))
                mepc_q <= csr_op(mepc_q, wdata, mode_sel_i) & 32'hFFFF_FFFC;

            if (accept)
                mcause_q <= win_cause;
            else if (wr_en && !cause_lock && (addr_i == A_MCAUSE))
                mcause_q <= csr_op(mcause_q, wdata, mode_sel_i);
        end
    end

    always_comb begin
        case (addr_i)
            A_MSTATUS:  csr_data_o = mstatus_rd;
            A_MIE:      csr_data_o = mie_q;
            A_MTVEC:    csr_data_o = mtvec_q;
            A_MSCRATCH: csr_data_o = mscratch_q;
            A_MEPC:     csr_data_o = mepc_q;
            A_MCAUSE:   csr_data_o = mcause_q;
            A_MIP:      csr_data_o = mip;
            A_MHARTID:  csr_data_o = HARTID;
            default:    csr_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Directed and randomized checks of csr_irq_ctrl against a behavioural CSR/interrupt model.
module tb_csr_irq_ctrl;
    localparam int          NI  = 4;
    localparam int          FC  = 3;
    localparam logic [31:0] HID = 32'h0000_00A5;

    logic          clk = 1'b0;
    logic          rst_n, csr_wr, imm_sel, timer, stall, hold, mret, ctrl;
    logic [11:0]   addr;
    logic [1:0]    mode;
    logic [4:0]    immed;
    logic [31:0]   rs1, next_pc, csr_data, pc_addr;
    logic [NI-1:0] irq, ack;
    logic          flush, pc_sel, busy;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] m_ms, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;

    csr_irq_ctrl #(.NUM_IRQ(NI), .FLUSH_CYCLES(FC), .HARTID(HID), .VECTORED(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .csr_wr_i(csr_wr), .addr_i(addr), .mode_sel_i(mode),
        .immed_i(immed), .immed_sel_i(imm_sel), .rs1_i(rs1), .irq_i(irq),
        .timer_intr_i(timer), .stall_i(stall), .hold_i(hold), .mret_i(mret),
        .ctrl_change_i(ctrl), .next_pc_i(next_pc), .csr_data_o(csr_data), .flush_o(flush),
        .pc_intr_sel_o(pc_sel), .pc_intr_addr_o(pc_addr), .irq_ack_o(ack), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, csr_data, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] m, input logic [31:0] v, input bit imm);
        csr_wr = 1'b1; addr = a; mode = m; imm_sel = imm;
        if (imm) immed = v[4:0]; else rs1 = v;
        tick();
        csr_wr = 1'b0;
    endtask

    function automatic logic [31:0] f_op(input logic [31:0] old, input logic [31:0] wd, input logic [1:0] m);
        if (m == 2'd1) return wd;
        if (m == 2'd2) return old | wd;
        if (m == 2'd3) return old & ~wd;
        return old;
    endfunction

    function automatic logic [31:0] mie_mask();
        logic [31:0] r = 32'h80;
        for (int k = 0; k < NI; k++) r = r + (32'h1 << (16 + k));
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input logic [11:0] a, input logic [NI-1:0] ir, input logic t);
        case (a)
            12'h300: return m_ms;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (32'(ir) << 16) + (t ? 32'd128 : 32'd0);
            12'hF14: return HID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [11:0] a, input logic [1:0] m, input logic [31:0] wd);
        case (a)
            12'h300: m_ms       = f_op(m_ms, wd, m) & 32'h88;
            12'h304: m_mie      = f_op(m_mie, wd, m) & mie_mask();
            12'h305: m_mtvec    = f_op(m_mtvec, wd, m) & 32'hFFFF_FFFD;
            12'h340: m_mscratch = f_op(m_mscratch, wd, m);
            12'h341: m_mepc     = f_op(m_mepc, wd, m) & 32'hFFFF_FFFC;
            12'h342: m_mcause   = f_op(m_mcause, wd, m);
            default: ;
        endcase
    endfunction

    // Lowest-numbered enabled external line wins, timer last.
    function automatic logic [31:0] cause_of(input logic [NI-1:0] ext, input logic t);
        for (int k = 0; k < NI; k++)
            if (ext[k]) return 32'h8000_0000 + 32'(16 + k);
        return t ? 32'h8000_0007 : 32'd0;
    endfunction

    function automatic logic [31:0] tgt(input logic [31:0] tv, input logic [31:0] cause);
        logic [31:0] base = tv - (tv % 4);
        return tv[0] ? base + 4 * (cause % 32) : base;
    endfunction

    logic [11:0] alist [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'h344, 12'hF14, 12'h7C0};

    initial begin
        logic [31:0] wd, c;
        logic [11:0] a;
        rst_n = 1'b0; csr_wr = 0; addr = '0; mode = '0; immed = '0; imm_sel = 0; rs1 = '0;
        irq = '0; timer = 0; stall = 0; hold = 0; mret = 0; ctrl = 0; next_pc = '0;
        tick(); tick();
        #1;
        chk("rst_flush", 32'(flush), 0);
        chk("rst_sel", 32'(pc_sel), 0);
        chk("rst_addr", pc_addr, 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk_rd("rst_mstatus", 12'h300, 0);
        chk_rd("rst_mtvec", 12'h305, 0);
        chk_rd("rst_mcause", 12'h342, 0);
        chk_rd("hartid", 12'hF14, HID);
        rst_n = 1'b1;
        tick();

        // CSR operations
        wr(12'h304, 2'd1, 32'h10000, 0);
        wr(12'h304, 2'd2, 32'h1F, 1);
        chk_rd("csrrs_mie_zimm", 12'h304, 32'h10000);
        wr(12'h7C0, 2'd1, 32'hFFFF_FFFF, 0);
        chk_rd("unimpl_read", 12'h7C0, 0);
        wr(12'h344, 2'd1, 32'hFFFF_FFFF, 0);
        chk_rd("mip_ro", 12'h344, 0);
        irq = 4'b0101; timer = 1;
        chk_rd("mip_live", 12'h344, 32'h50080);
        irq = '0; timer = 0;
        wr(12'h341, 2'd1, 32'h47, 0);
        chk_rd("mepc_lowbits", 12'h341, 32'h44);
        wr(12'h305, 2'd1, 32'h100, 0);
        wr(12'h300, 2'd1, 32'h8, 0);
        chk_rd("mstatus_mie", 12'h300, 32'h8);

        // Basic entry
        irq = 4'b0001; next_pc = 32'h40;
        #1;
        chk("pre_busy", 32'(busy), 0);
        tick();
        irq = '0;
        c = cause_of(4'b0001, 0);
        #1;
        chk("e1_busy", 32'(busy), 1);
        chk("e1_flush", 32'(flush), 1);
        chk("e1_sel", 32'(pc_sel), 0);
        chk("e1_ack", 32'(ack), 32'b0001);
        chk_rd("e1_mcause", 12'h342, c);
        chk_rd("e1_mepc", 12'h341, 32'h40);
        chk_rd("e1_mstatus", 12'h300, 32'h80);
        tick();
        #1;
        chk("e2_flush", 32'(flush), 1);
        chk("e2_ack", 32'(ack), 0);
        tick();
        #1;
        chk("e3_flush", 32'(flush), 0);
        chk("e3_sel", 32'(pc_sel), 1);
        chk("e3_addr", pc_addr, tgt(32'h100, c));
        tick();
        irq = 4'b0001;
        #1;
        chk("act_sel", 32'(pc_sel), 0);
        tick();
        #1;
        chk("no_nest_busy", 32'(busy), 1);
        chk("no_nest_ack", 32'(ack), 0);
        irq = '0; mret = 1;
        #1;
        chk("mret_sel", 32'(pc_sel), 1);
        chk("mret_addr", pc_addr, 32'h40);
        tick();
        #1;
        chk("idle_mret_sel", 32'(pc_sel), 0);
        chk("idle_mret_busy", 32'(busy), 0);
        chk_rd("mret_mstatus", 12'h300, 32'h88);
        mret = 0;

        // Priority, vectored target, mcause write lock
        wr(12'h304, 2'd1, 32'hF0080, 0);
        wr(12'h305, 2'd1, 32'h201, 0);
        irq = 4'b1010; timer = 1;
        tick();
        irq = '0; timer = 0;
        c = cause_of(4'b1010, 1);
        #1;
        chk("prio_ack", 32'(ack), 32'b0010);
        chk_rd("prio_mcause", 12'h342, c);
        wr(12'h342, 2'd1, 32'h1234, 0);
        chk_rd("mcause_locked", 12'h342, c);
        tick();
        #1;
        chk("prio_sel", 32'(pc_sel), 1);
        chk("prio_vec_addr", pc_addr, tgt(32'h201, c));
        tick();
        mret = 1;
        tick();
        mret = 0;

        // Timer entry with stall, hold and a control transfer
        timer = 1; next_pc = 32'h2000;
        tick();
        timer = 0;
        c = cause_of('0, 1);
        for (int i = 0; i < 6; i++) begin
            stall = (i < 2); hold = (i == 4); ctrl = (i == 2);
            next_pc = (i == 2) ? 32'h88 : 32'h3000;
            #1;
            chk("sh_busy", 32'(busy), 1);
            chk("sh_flush", 32'(flush), (i < 4) ? 1 : 0);
            chk("sh_sel", 32'(pc_sel), (i >= 4) ? 1 : 0);
            chk("sh_addr", pc_addr, (i >= 4) ? tgt(32'h201, c) : 0);
            tick();
        end
        stall = 0; hold = 0; ctrl = 0;
        #1;
        chk("sh_active_sel", 32'(pc_sel), 0);
        chk_rd("sh_mepc", 12'h341, 32'h88);
        mret = 1;
        #1;
        chk("sh_mret_addr", pc_addr, 32'h88);
        tick();
        mret = 0;

        // Reset in the middle of entry
        irq = 4'b0100;
        tick();
        irq = '0;
        #1;
        chk("mid_busy", 32'(busy), 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        chk("rst_mid_sel", 32'(pc_sel), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_ack", 32'(ack), 0);
        chk_rd("rst_mid_mstatus", 12'h300, 0);

        // Randomized CSR traffic with MIE kept clear
        m_ms = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        for (int n = 0; n < 80; n++) begin
            a = alist[$urandom_range(0, 8)];
            mode = 2'($urandom_range(0, 3));
            imm_sel = 1'($urandom_range(0, 1));
            rs1 = $urandom;
            immed = 5'($urandom);
            irq = NI'($urandom);
            timer = 1'($urandom_range(0, 1));
            if (a == 12'h300) begin
                rs1[3] = 1'b0;
                immed[3] = 1'b0;
            end
            wd = imm_sel ? {27'b0, immed} : rs1;
            addr = a; csr_wr = (mode != 0) || ($urandom_range(0, 1) == 1);
            #1;
            chk("rnd_busy", 32'(busy), 0);
            tick();
            if (csr_wr) model_write(a, mode, wd);
            csr_wr = 0;
            a = alist[$urandom_range(0, 8)];
            chk_rd("rnd_read", a, exp_read(a, irq, timer));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
